instr_fifo: RTL and testbench

Per-lane instruction queue that sits directly downstream of the instruction arbiter. There is one instance each behind the arbiter's `FIFO_1` and `FIFO_2` outputs. It buffers 32-bit instructions the arbiter routes to its lane and presents them in order, first-word-fall-through, to that lane's fetch/decode stage. It also reports occupancy and sticky error flags so the arbiter can stop routing to a full lane.

---
 rtl/instr_pkg.sv | 31 +++
 rtl/instr_fifo_mem.sv | 30 +++
 rtl/instr_fifo.sv | 97 +++++++++
 tb/tb_instr_fifo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// instr_pkg: shared instruction definitions for the arbiter lanes and their
// per-lane instruction FIFOs.
//   INSTR_W      : instruction width
//   OPCODE_*     : opcode field [31:29]
//   ROUTE_*      : route override field [28:27] (2'b10 -> lane 1, 2'b11 -> lane 2)
//   SRC_* / DST_*: source / destination address fields
//   instr_t      : packed view of one instruction
package instr_pkg;

  localparam int INSTR_W = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 29;
  localparam int ROUTE_MSB  = 28;
  localparam int ROUTE_LSB  = 27;
  localparam int SRC_MSB    = 26;
  localparam int SRC_LSB    = 14;
  localparam int DST_MSB    = 13;
  localparam int DST_LSB    = 0;

  localparam logic [1:0] ROUTE_LANE1 = 2'b10;
  localparam logic [1:0] ROUTE_LANE2 = 2'b11;

  typedef struct packed {
    logic [OPCODE_MSB-OPCODE_LSB:0] opcode;
    logic [ROUTE_MSB-ROUTE_LSB:0]   route;
    logic [SRC_MSB-SRC_LSB:0]       src;
    logic [DST_MSB-DST_LSB:0]       dst;
  } instr_t;

endpackage

// File: rtl/instr_fifo_mem.sv
// instr_fifo_mem: DEPTH x DATA_W storage array for instr_fifo.
//   clk    : write clock
//   i_we   : write enable
//   i_waddr: write address
//   i_wdata: write data
//   i_raddr: read address (asynchronous read)
//   o_rdata: read data
// Contents are intentionally not reset.
module instr_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fifo.sv
// instr_fifo: per-lane first-word-fall-through instruction queue behind the
// instruction arbiter.
//   clk, reset      : clock, asynchronous active-high reset
//   push, din, full : write side (push while full is dropped)
//   pop, dout, empty: read side (dout valid while empty=0)
//   count           : occupancy 0..DEPTH
//   overflow        : sticky, push while full
//   underflow       : sticky, pop while empty
// Optional macro INSTR_FIFO_BYPASS_EN: when empty, din is forwarded to dout
// combinationally, and a same-cycle push+pop consumes the word without
// storing it.
module instr_fifo
  import instr_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = INSTR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  output logic                       full,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_bypass;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [DATA_W-1:0] w_rdata;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                   (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

`ifdef INSTR_FIFO_BYPASS_EN
  // Word passes straight through when the queue is empty and consumed now.
  assign w_bypass = w_empty && push && pop;
  assign dout     = (w_empty && push) ? din : w_rdata;
`else
  assign w_bypass = 1'b0;
  assign dout     = w_rdata;
`endif

  // full/empty are taken from pre-edge state, so a pop never frees a slot
  // for a push in the same cycle.
  assign w_push_ok = push && !w_full && !w_bypass;
  assign w_pop_ok  = pop && !w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (push && w_full) r_overflow <= 1'b1;
      if (pop && w_empty && !w_bypass) r_underflow <= 1'b1;
    end
  end

  instr_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (din),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_wr_ptr - r_rd_ptr;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_instr_fifo.sv
module tb_instr_fifo;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              push;
  logic [DATA_W-1:0] din;
  logic              full;
  logic              pop;
  logic [DATA_W-1:0] dout;
  logic              empty;
  logic [3:0]        count;
  logic              overflow;
  logic              underflow;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: a plain queue plus the two sticky flags
  logic [DATA_W-1:0] q[$];
  bit                m_ovf;
  bit                m_unf;

  instr_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .din       (din),
    .full      (full),
    .pop       (pop),
    .dout      (dout),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    if (q.size() != 0) chk({tag, ".dout"}, dout, q[0]);
  endtask

  // One clock cycle with the given inputs; model updated from pre-edge state.
  task automatic step(input bit p, input logic [DATA_W-1:0] d, input bit pp, input string tag);
    bit was_full;
    bit was_empty;
    bit byp;
    @(negedge clk);
    push = p;
    din  = d;
    pop  = pp;
    #1;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    byp = 1'b0;
`ifdef INSTR_FIFO_BYPASS_EN
    if (was_empty && p) chk({tag, ".bypass_dout"}, dout, d);
    byp = was_empty && p && pp;
`endif
    if (!byp) begin
      if (pp) begin
        if (was_empty) m_unf = 1'b1;
        else void'(q.pop_front());
      end
      if (p) begin
        if (was_full) m_ovf = 1'b1;
        else q.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    chk_state(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    din   = '0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_state("reset");

    // three pushes then three pops, in order
    step(1, 32'h1000_0101, 0, "push0");
    step(1, 32'h1800_8080, 0, "push1");
    step(1, 32'h0000_0202, 0, "push2");
    chk("count3", 32'(count), 32'd3);
    step(0, '0, 1, "pop0");
    step(0, '0, 1, "pop1");
    step(0, '0, 1, "pop2");
    chk("empty_after3", 32'(empty), 32'd1);

    // fill, overflow, push+pop while full, drain
    for (int i = 0; i < DEPTH; i++) step(1, 32'hA000_0000 + 32'(i), 0, "fill");
    chk("full8", 32'(full), 32'd1);
    chk("count8", 32'(count), 32'd8);
    step(1, 32'hDEAD_BEEF, 0, "ovf_push");
    chk("ovf_set", 32'(overflow), 32'd1);
    step(1, 32'hCAFE_F00D, 1, "full_pushpop");
    chk("count7", 32'(count), 32'd7);
    for (int i = 0; i < DEPTH - 1; i++) step(0, '0, 1, "drain");

    // underflow and same-cycle push+pop from empty
    do_reset();
    chk_state("reset2");
    step(0, '0, 1, "unf_pop");
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    do_reset();
    step(1, 32'h1234_5678, 1, "empty_pushpop");
    step(0, '0, 1, "cleanup");

    // steady state at half occupancy across two pointer wraps
    do_reset();
    for (int i = 0; i < DEPTH / 2; i++) step(1, $urandom, 0, "half_fill");
    for (int i = 0; i < 20; i++) begin
      step(1, $urandom, 1, "wrap");
      chk("wrap_count", 32'(count), 32'(DEPTH / 2));
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      step(bit'($urandom_range(0, 1)), w, bit'($urandom_range(0, 1)), "rand");
    end

    // asynchronous reset mid-cycle
    do_reset();
    for (int i = 0; i < 5; i++) step(1, $urandom, 0, "pre_arst");
    step(1, $urandom, 1, "pre_arst_mix");
    @(posedge clk);
    #2;
    push = 1'b0;
    pop  = 1'b0;
    reset = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    chk_state("arst");
    chk("arst_count", 32'(count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 32'h0BAD_C0DE, 0, "post_arst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
